// File: rtl/key_press_ctrl.sv
// key_press_ctrl: per-key sync + debounce with press/release/long events.
// Ports: clk, rst_n, key_in (0=pressed), key_level, key_press, key_release,
// key_long. Optional auto-repeat in LONG_HELD via `define KEY_REPEAT_EN.
module key_press_ctrl #(
  parameter int NUM_KEYS        = 4,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int LONG_CYCLES     = 50000000,
  parameter int REPEAT_CYCLES   = 10000000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NUM_KEYS-1:0] key_in,
  output logic [NUM_KEYS-1:0] key_level,
  output logic [NUM_KEYS-1:0] key_press,
  output logic [NUM_KEYS-1:0] key_release,
  output logic [NUM_KEYS-1:0] key_long
);

  localparam int MAX_DL =
    (DEBOUNCE_CYCLES > LONG_CYCLES) ? DEBOUNCE_CYCLES : LONG_CYCLES;
`ifdef KEY_REPEAT_EN
  localparam int MAXC =
    (MAX_DL > REPEAT_CYCLES) ? MAX_DL : REPEAT_CYCLES;
`else
  localparam int MAXC = MAX_DL;
`endif
  localparam int CW = (MAXC > 1) ? $clog2(MAXC) : 1;

  localparam logic [CW-1:0] DB_LAST   = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] LONG_LAST = CW'(LONG_CYCLES - 1);
`ifdef KEY_REPEAT_EN
  localparam logic [CW-1:0] REP_LAST  = CW'(REPEAT_CYCLES - 1);
`endif

  if (DEBOUNCE_CYCLES < 1 || LONG_CYCLES < 1 ||
      REPEAT_CYCLES < 1) begin : g_bad_param
    $error("key_press_ctrl: cycle parameters must be >= 1");
  end

  typedef enum logic [2:0] {
    IDLE,
    PRESS_DB,
    HELD,
    LONG_HELD,
    RELEASE_DB
  } state_t;

  function automatic logic [CW-1:0] inc(input logic [CW-1:0] c);
    return (&c) ? c : c + CW'(1);
  endfunction

  // Synchronizer flops idle at 1 so reset looks like "released".
  logic [NUM_KEYS-1:0] sync1;
  logic [NUM_KEYS-1:0] key_s;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '1;
      key_s <= '1;
    end else begin
      sync1 <= key_in;
      key_s <= sync1;
    end
  end

  for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
    state_t        st;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt2;
    logic          long_flag;
    logic          level;
    logic          press;
    logic          rel;
    logic          lng;
`ifdef KEY_REPEAT_EN
    logic [CW-1:0] rcnt;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        st        <= IDLE;
        cnt       <= '0;
        cnt2      <= '0;
        long_flag <= 1'b0;
        level     <= 1'b0;
        press     <= 1'b0;
        rel       <= 1'b0;
        lng       <= 1'b0;
`ifdef KEY_REPEAT_EN
        rcnt      <= '0;
`endif
      end else begin
        press <= 1'b0;
        rel   <= 1'b0;
        lng   <= 1'b0;
        unique case (st)
          IDLE: begin
            if (!key_s[k]) begin
              st  <= PRESS_DB;
              cnt <= '0;
            end
          end
          PRESS_DB: begin
            if (key_s[k]) begin
              st <= IDLE;
            end else if (cnt == DB_LAST) begin
              st    <= HELD;
              press <= 1'b1;
              level <= 1'b1;
              cnt   <= '0;
            end else begin
              cnt <= inc(cnt);
            end
          end
          HELD: begin
            if (key_s[k]) begin
              st   <= RELEASE_DB;
              cnt2 <= '0;
            end else if (cnt == LONG_LAST) begin
              st  <= LONG_HELD;
              lng <= 1'b1;
              cnt <= '0;
`ifdef KEY_REPEAT_EN
              rcnt <= '0;
`endif
            end else begin
              cnt <= inc(cnt);
            end
          end
          LONG_HELD: begin
            if (key_s[k]) begin
              st        <= RELEASE_DB;
              cnt2      <= '0;
              long_flag <= 1'b1;
            end
`ifdef KEY_REPEAT_EN
            else if (rcnt == REP_LAST) begin
              press <= 1'b1;
              rcnt  <= '0;
            end else begin
              rcnt <= inc(rcnt);
            end
`endif
          end
          RELEASE_DB: begin
            // A glitch back to low resumes the hold; the long flag
            // keeps a second key_long from firing for this press.
            if (!key_s[k]) begin
              st  <= long_flag ? LONG_HELD : HELD;
              cnt <= '0;
            end else if (cnt2 == DB_LAST) begin
              st        <= IDLE;
              rel       <= 1'b1;
              level     <= 1'b0;
              long_flag <= 1'b0;
            end else begin
              cnt2 <= inc(cnt2);
            end
          end
          default: st <= IDLE;
        endcase
      end
    end

    assign key_level[k]   = level;
    assign key_press[k]   = press;
    assign key_release[k] = rel;
    assign key_long[k]    = lng;
  end

endmodule

// File: tb/tb_key_press_ctrl.sv
// tb_key_press_ctrl: directed bench for key_press_ctrl.
// Small timing params; expectations counted in clock edges.
module tb_key_press_ctrl;

  logic       clk;
  logic       rst_n;
  logic [3:0] key_in;
  logic [3:0] key_level;
  logic [3:0] key_press;
  logic [3:0] key_release;
  logic [3:0] key_long;

  int checks;
  int errors;

  key_press_ctrl #(
    .NUM_KEYS       (4),
    .DEBOUNCE_CYCLES(4),
    .LONG_CYCLES    (20),
    .REPEAT_CYCLES  (5)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .key_in     (key_in),
    .key_level  (key_level),
    .key_press  (key_press),
    .key_release(key_release),
    .key_long   (key_long)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

`ifdef KEY_REPEAT_EN
  localparam int LP_REPS  = 4;
  localparam int LP_FIRST = 25;
  localparam int GL_REPS  = 1;
`else
  localparam int LP_REPS  = 0;
  localparam int LP_FIRST = -1;
  localparam int GL_REPS  = 0;
`endif

  int longs;
  int long_at;
  int reps;
  int first_rep;
  int rels;
  logic [3:0] seen;

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    key_in = 4'b0000;

    // Reset with all keys pressed.
    ticks(3);
    check("rst_level", key_level, 0);
    check("rst_press", key_press, 0);
    check("rst_release", key_release, 0);
    check("rst_long", key_long, 0);
    rst_n = 1'b1;
    ticks(6);
    check("rst_press_early", key_press, 0);
    tick();
    check("rst_press_all", key_press, 4'b1111);
    check("rst_level_all", key_level, 4'b1111);
    tick();
    check("rst_press_single", key_press, 0);
    key_in = 4'b1111;
    ticks(6);
    check("rst_rel_early", key_release, 0);
    tick();
    check("rst_rel_all", key_release, 4'b1111);
    check("rst_level_off", key_level, 0);

    // Bounce on key 1.
    ticks(3);
    seen = '0;
    key_in[1] = 1'b0;
    for (int i = 0; i < 3; i++) begin tick(); seen |= key_press; end
    key_in[1] = 1'b1;
    tick(); seen |= key_press;
    key_in[1] = 1'b0;
    for (int i = 0; i < 2; i++) begin tick(); seen |= key_press; end
    key_in[1] = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick(); seen |= key_press | key_level;
    end
    check("bounce_none", seen, 0);

    // Clean press/release on key 0.
    key_in[0] = 1'b0;
    ticks(6);
    check("k0_press_early", key_press, 0);
    tick();
    check("k0_press", key_press, 4'b0001);
    check("k0_level_on", key_level, 4'b0001);
    tick();
    check("k0_press_single", key_press, 0);
    ticks(2);
    key_in[0] = 1'b1;
    ticks(6);
    check("k0_rel_early", key_release, 0);
    check("k0_level_hold", key_level, 4'b0001);
    tick();
    check("k0_release", key_release, 4'b0001);
    check("k0_level_off", key_level, 0);
    tick();
    check("k0_rel_single", key_release, 0);

    // Long press on key 2, held 40 edges past key_press.
    key_in[2] = 1'b0;
    ticks(7);
    check("k2_press", key_press, 4'b0100);
    longs = 0; long_at = -1; reps = 0; first_rep = -1;
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (key_long[2]) begin
        longs++;
        if (long_at < 0) long_at = k;
      end
      if (key_press[2]) begin
        reps++;
        if (first_rep < 0) first_rep = k;
      end
    end
    check("k2_long_count", longs, 1);
    check("k2_long_at", long_at, 20);
    check("k2_repeat_count", reps, LP_REPS);
    check("k2_first_repeat", first_rep, LP_FIRST);
    key_in[2] = 1'b1;
    ticks(6);
    check("k2_rel_early", key_release, 0);
    tick();
    check("k2_release", key_release, 4'b0100);

    // Release glitch on key 3 during HELD.
    ticks(2);
    key_in[3] = 1'b0;
    ticks(7);
    check("k3_press", key_press, 4'b1000);
    longs = 0; long_at = -1; reps = 0; rels = 0;
    for (int k = 1; k <= 35; k++) begin
      if (k == 4) key_in[3] = 1'b1;
      if (k == 6) key_in[3] = 1'b0;
      tick();
      if (key_long[3]) begin
        longs++;
        if (long_at < 0) long_at = k;
      end
      if (key_press[3]) reps++;
      if (key_release[3]) rels++;
    end
    check("k3_glitch_norel", rels, 0);
    check("k3_long_count", longs, 1);
    check("k3_long_at", long_at, 28);
    check("k3_repeat_count", reps, GL_REPS);
    key_in[3] = 1'b1;
    ticks(7);
    check("k3_release", key_release, 4'b1000);

    // Simultaneous press on keys 0 and 3, then reset mid-hold.
    ticks(2);
    key_in = 4'b0110;
    ticks(7);
    check("sim_press", key_press, 4'b1001);
    check("sim_level", key_level, 4'b1001);
    ticks(3);
    rst_n = 1'b0;
    #1;
    check("mid_rst_level", key_level, 0);
    check("mid_rst_press", key_press, 0);
    key_in = 4'b1111;
    ticks(2);
    rst_n = 1'b1;
    seen = '0;
    for (int i = 0; i < 12; i++) begin
      tick(); seen |= key_release | key_press | key_long;
    end
    check("mid_rst_nopulse", seen, 0);
    check("mid_rst_level_off", key_level, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
